pipelined_csel_adder: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 4-bit

---
 rtl/pipelined_csel_adder.sv | 130 +++++++++++++
 tb/tb_pipelined_csel_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_csel_adder
// Brief    : Pipelined carry-select adder/subtractor, one BLOCK-bit slice per
//            stage, valid/ready on both sides. Define OVERFLOW_FLAG_EN to add
//            the registered signed-overflow output ovf.
// Revision : 1.0  initial release
// ============================================================================
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = WIDTH / BLOCK;

  logic             w_adv;

  // Per-stage inputs: operands, partial sum so far, incoming carry, valid
  logic [WIDTH-1:0] w_stg_a [NBLK];
  logic [WIDTH-1:0] w_stg_b [NBLK];
  logic [WIDTH-1:0] w_stg_s [NBLK];
  logic             w_stg_c [NBLK];
  logic             w_stg_v [NBLK];
  logic [WIDTH-1:0] w_nxt_s [NBLK];
  logic             w_nxt_c [NBLK];

  logic [WIDTH-1:0] r_a [NBLK];
  logic [WIDTH-1:0] r_b [NBLK];
  logic [WIDTH-1:0] r_s [NBLK];
  logic             r_c [NBLK];
  logic             r_v [NBLK];

  // The last stage register doubles as the output register, so a stall there
  // freezes the whole pipe.
  assign w_adv     = !r_v[NBLK-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v[NBLK-1];
  assign s         = r_s[NBLK-1];
  assign cout      = r_c[NBLK-1];

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    localparam int               LO         = k * BLOCK;
    localparam logic [WIDTH-1:0] HI_MASK    = {WIDTH{1'b1}} << (LO + BLOCK);
    localparam logic [WIDTH-1:0] SLICE_MASK = {{(WIDTH-BLOCK){1'b0}}, {BLOCK{1'b1}}} << LO;

    logic [BLOCK:0] w_sum0;
    logic [BLOCK:0] w_sum1;
    logic [BLOCK:0] w_sel;

    if (k == 0) begin : g_head
      assign w_stg_a[k] = a;
      assign w_stg_b[k] = sub ? ~b : b;
      assign w_stg_c[k] = sub | cin;
      assign w_stg_s[k] = '0;
      assign w_stg_v[k] = in_valid;
    end else begin : g_body
      assign w_stg_a[k] = r_a[k-1];
      assign w_stg_b[k] = r_b[k-1];
      assign w_stg_c[k] = r_c[k-1];
      assign w_stg_s[k] = r_s[k-1];
      assign w_stg_v[k] = r_v[k-1];
    end

    // Both carry hypotheses are formed in parallel; the incoming carry only selects.
    assign w_sum0 = {1'b0, w_stg_a[k][LO +: BLOCK]} + {1'b0, w_stg_b[k][LO +: BLOCK]};
    assign w_sum1 = {1'b0, w_stg_a[k][LO +: BLOCK]} + {1'b0, w_stg_b[k][LO +: BLOCK]}
                  + {{BLOCK{1'b0}}, 1'b1};
    assign w_sel  = w_stg_c[k] ? w_sum1 : w_sum0;

    assign w_nxt_s[k] = (w_stg_s[k] & ~SLICE_MASK)
                      | ({{(WIDTH-BLOCK){1'b0}}, w_sel[BLOCK-1:0]} << LO);
    assign w_nxt_c[k] = w_sel[BLOCK];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v[k] <= 1'b0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
      end else if (w_adv) begin
        r_v[k] <= w_stg_v[k];
        if (w_stg_v[k]) begin
          r_s[k] <= w_nxt_s[k];
          r_c[k] <= w_nxt_c[k];
          r_a[k] <= w_stg_a[k] & HI_MASK;
          r_b[k] <= w_stg_b[k] & HI_MASK;
        end
      end
    end
  end

`ifdef OVERFLOW_FLAG_EN
  // Operand sign bits ride in the upper operand pipeline until the last slice.
  logic w_ovf;
  logic r_ovf;

  assign w_ovf = (w_stg_a[NBLK-1][WIDTH-1] == w_stg_b[NBLK-1][WIDTH-1])
               & (w_nxt_s[NBLK-1][WIDTH-1] != w_stg_a[NBLK-1][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv && w_stg_v[NBLK-1]) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csel_adder.sv
`default_nettype none
// Self-checking bench for pipelined_csel_adder (WIDTH=16, BLOCK=4) with a
// queue-based arithmetic reference model.
module tb_pipelined_csel_adder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b, s;
  logic        cin, sub, in_valid, in_ready, out_valid, out_ready, cout;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int vectors     = 0;
  int miscompares = 0;

  typedef logic [17:0] res_t;  // {ovf, cout, s}
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .cout     (cout),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  // Plain integer arithmetic: subtraction is a - b with cout meaning "no borrow".
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    logic [16:0] full;
    int          sr;
    if (sb) begin
      full = {1'b0, x} + (17'h10000 - {1'b0, y});
      sr   = int'($signed(x)) - int'($signed(y));
    end else begin
      full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      sr   = int'($signed(x)) + int'($signed(y)) + (ci ? 1 : 0);
    end
    return {(sr > 32767 || sr < -32768), full};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
    cin = 1'b1; sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (s !== 16'h0000) begin miscompares++; $display("FAIL reset_s: got %h expected 0000", s); end
    vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b expected 0", cout); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef OVERFLOW_FLAG_EN
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
  endtask

  task automatic test_directed();
    vec_t tab[8];
    tab[0] = '{16'h0005, 16'h000D, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0};
    tab[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tab[2] = '{16'h0005, 16'h000D, 1'b1, 1'b1, 16'hFFF8, 1'b0, 1'b0};
    tab[3] = '{16'h000D, 16'h0005, 1'b0, 1'b1, 16'h0008, 1'b1, 1'b0};
    tab[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tab[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tab[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tab[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      int lat;
      @(posedge clk); #1;
      a = tab[i].a; b = tab[i].b; cin = tab[i].ci; sub = tab[i].sb;
      in_valid = 1'b1; out_ready = 1'b1; #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~sub; #1;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #2;
        lat++;
      end
      vectors++; if (lat != LAT) begin miscompares++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT); end
      vectors++; if (s !== tab[i].s) begin miscompares++; $display("FAIL dir%0d_s: got %h expected %h", i, s, tab[i].s); end
      vectors++; if (cout !== tab[i].co) begin miscompares++; $display("FAIL dir%0d_cout: got %b expected %b", i, cout, tab[i].co); end
`ifdef OVERFLOW_FLAG_EN
      vectors++; if (ovf !== tab[i].ov) begin miscompares++; $display("FAIL dir%0d_ovf: got %b expected %b", i, ovf, tab[i].ov); end
`endif
    end
  endtask

  task automatic test_stream();
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    logic [15:0] held = '0;
    res_t        e;
    exp_q.delete();
    while (got < 8 && cyc < 60) begin
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid  = (sent < 8);
      out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      if (cyc >= 6 && cyc <= 8) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stream_stall_in_ready: got %b expected 0 (cycle %0d)", in_ready, cyc); end
        if (cyc == 6) held = s;
        else begin
          vectors++; if (s !== held) begin miscompares++; $display("FAIL stream_stall_hold: got %h expected %h", s, held); end
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL stream_extra_result: got %h expected none", s);
        end else begin
          e = exp_q.pop_front();
          if ({cout, s} !== e[16:0]) begin miscompares++; $display("FAIL stream_result%0d: got %h expected %h", got, {cout, s}, e[16:0]); end
`ifdef OVERFLOW_FLAG_EN
          vectors++; if (ovf !== e[17]) begin miscompares++; $display("FAIL stream_ovf%0d: got %b expected %b", got, ovf, e[17]); end
`endif
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    vectors++; if (got != 8 || exp_q.size() != 0) begin miscompares++; $display("FAIL stream_count: got %0d results expected 8 (pending %0d)", got, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_s = '0;
    res_t        e;
    exp_q.delete();
    while (cyc < 40 || (exp_q.size() != 0 && cyc < 80)) begin
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid  = (cyc < 40) && ($urandom_range(0, 3) != 0);
      out_ready = (cyc >= 40) || ($urandom_range(0, 9) < 7);
      #1;
      vectors++; if (in_ready !== (!out_valid || out_ready)) begin miscompares++; $display("FAIL b2b_in_ready: got %b expected %b", in_ready, !out_valid || out_ready); end
      if (prev_stall) begin
        vectors++; if (out_valid !== 1'b1 || s !== prev_s) begin miscompares++; $display("FAIL b2b_hold: got %b/%h expected 1/%h", out_valid, s, prev_s); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra_result: got %h expected none", s);
        end else begin
          e = exp_q.pop_front();
          if ({cout, s} !== e[16:0]) begin miscompares++; $display("FAIL b2b_result: got %h expected %h", {cout, s}, e[16:0]); end
`ifdef OVERFLOW_FLAG_EN
          vectors++; if (ovf !== e[17]) begin miscompares++; $display("FAIL b2b_ovf: got %b expected %b", ovf, e[17]); end
`endif
        end
      end
      if (in_valid && in_ready === 1'b1) exp_q.push_back(model(a, b, cin, sub));
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_s     = s;
      cyc++;
    end
    in_valid = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a = 16'($urandom | 1); b = 16'($urandom); cin = 1'b1; sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1; #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready%0d: got %b expected 1", i, in_ready); end
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1; rst = 1'b1; #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid); end
    @(posedge clk); #1; rst = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    vectors++; if (s !== 16'h0000) begin miscompares++; $display("FAIL rstmid_s: got %h expected 0000", s); end
    vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL rstmid_cout: got %b expected 0", cout); end
    out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #2;
      if (out_valid !== 1'b0) stale++;
    end
    vectors++; if (stale != 0) begin miscompares++; $display("FAIL rstmid_stale: got %0d valid cycles expected 0", stale); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
